// File: rtl/latch_readout_serializer.sv
// Parallel-load, MSB-first serializer with a valid/ready handshake on the serial side.
// Three-state FSM (IDLE, SHIFT, DONE); every output comes from a register.
module latch_readout_serializer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] D,
  input  logic             load,
  input  logic             sout_ready,
  output logic             Q,
  output logic             Qdash,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CntW-1:0]  r_cnt;
  logic             r_q;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;

  // Outputs are loaded with the values for the state being entered, so they stay registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_shift <= '0;
      r_cnt   <= '0;
      r_q     <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (load) begin
            r_state <= StShift;
            r_shift <= D;
            r_cnt   <= CntW'(WIDTH - 1);
            r_q     <= D[WIDTH-1];
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        StShift: begin
          if (sout_ready) begin
            if (r_cnt != '0) begin
              r_shift <= {r_shift[WIDTH-2:0], 1'b0};
              r_cnt   <= r_cnt - CntW'(1);
              r_q     <= r_shift[WIDTH-2];
            end else begin
              r_state <= StDone;
              r_shift <= '0;
              r_q     <= 1'b0;
              r_valid <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= StIdle;
          r_shift <= '0;
          r_cnt   <= '0;
          r_q     <= 1'b0;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign Q     = r_q;
  assign Qdash = ~r_q;
  assign valid = r_valid;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_latch_readout_serializer.sv
// Bench for latch_readout_serializer: directed table, hand-written corner sequences and
// randomized traffic against a bit-queue reference model.
module tb_latch_readout_serializer;

  logic       clk = 1'b0;
  logic       rst_n, load, sout_ready;
  logic [7:0] D;
  logic       Q, Qdash, valid, busy, done;

  logic       load2, rdy2;
  logic [1:0] d2;
  logic       q2, qd2, v2, b2, dn2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  latch_readout_serializer #(.WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .D(D), .load(load), .sout_ready(sout_ready),
    .Q(Q), .Qdash(Qdash), .valid(valid), .busy(busy), .done(done)
  );

  latch_readout_serializer #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .D(d2), .load(load2), .sout_ready(rdy2),
    .Q(q2), .Qdash(qd2), .valid(v2), .busy(b2), .done(dn2)
  );

  // Reference model: bits still to be offered, plus a pending done-cycle flag.
  logic m_q[$];
  logic m_done = 1'b0;

  task automatic model_update(input logic r, input logic l, input logic [7:0] d, input logic rdy);
    if (!r) begin
      m_q.delete();
      m_done = 1'b0;
    end else if (m_q.size() > 0) begin
      if (rdy) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_done = 1'b1;
      end
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (l) begin
      for (int i = 7; i >= 0; i--) m_q.push_back(d[i]);
    end
  endtask

  function automatic logic [4:0] model_vec();
    logic v, q;
    v = (m_q.size() > 0);
    q = v ? m_q[0] : 1'b0;
    return {q, ~q, v, v | m_done, m_done};
  endfunction

  function automatic logic [4:0] dut_vec();
    return {Q, Qdash, valid, busy, done};
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic l, input logic [7:0] d, input logic rdy,
                      input string nm);
    rst_n = r; load = l; D = d; sout_ready = rdy;
    @(posedge clk);
    model_update(r, l, d, rdy);
    #1;
    check(nm, 32'(dut_vec()), 32'(model_vec()));
  endtask

  // Loads d with sout_ready=1 and gathers the serial bits until done (load/D held as given).
  task automatic run_collect(input logic [7:0] d, input logic hold_l, input logic [7:0] hold_d,
                             input string nm, output logic [7:0] bits);
    int n;
    bits = '0;
    n = 0;
    step(1'b1, 1'b1, d, 1'b1, nm);
    while (!done && n < 40) begin
      if (valid) bits = {bits[6:0], Q};
      step(1'b1, hold_l, hold_d, 1'b1, nm);
      n++;
    end
    check({nm, "_timeout"}, 32'(done), 32'd1);
  endtask

  typedef struct packed {
    logic       rst_n;
    logic       load;
    logic [7:0] d;
    logic       ready;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl[11];

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a5, bits;
    int nvalid, ndone, t, d0, d1, d2t;

    a5 = 8'hA5;
    load2 = 1'b0; rdy2 = 1'b1; d2 = 2'b00;

    // Reset, then A5 frame with sout_ready held high.
    tbl[0]  = '{1'b0, 1'b0, 8'h00, 1'b1, 5'b01000};
    tbl[1]  = '{1'b1, 1'b1, 8'hA5, 1'b1, 5'b10110};
    for (int i = 1; i < 8; i++)
      tbl[i+1] = '{1'b1, 1'b0, 8'h00, 1'b1, (a5[7-i] ? 5'b10110 : 5'b01110)};
    tbl[9]  = '{1'b1, 1'b0, 8'h00, 1'b1, 5'b01011};
    tbl[10] = '{1'b1, 1'b0, 8'h00, 1'b1, 5'b01000};
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].rst_n, tbl[i].load, tbl[i].d, tbl[i].ready, "tbl_model");
      check($sformatf("tbl_%0d", i), 32'(dut_vec()), 32'(tbl[i].exp));
    end

    // C3 with a 3-cycle stall after the second bit.
    step(1'b1, 1'b1, 8'hC3, 1'b1, "stall");
    nvalid = 1;
    t = 0;
    while (!done && t < 40) begin
      step(1'b1, 1'b0, 8'h00, !(t >= 1 && t <= 3), "stall");
      if (t >= 1 && t <= 3) check("stall_hold", 32'({Q, valid}), 32'b11);
      if (valid) nvalid++;
      t++;
    end
    check("stall_len", 32'(nvalid), 32'd11);
    check("stall_done", 32'(done), 32'd1);
    step(1'b1, 1'b0, 8'h00, 1'b1, "stall_idle");

    // Load requests during SHIFT and DONE are ignored.
    run_collect(8'h0F, 1'b1, 8'hFF, "ign", bits);
    check("ign_bits", 32'(bits), 32'h0F);
    step(1'b1, 1'b1, 8'hFF, 1'b1, "ign_done_load");
    check("ign_no_frame", 32'({valid, busy}), 32'b00);
    step(1'b1, 1'b0, 8'h00, 1'b1, "ign_idle");

    // Reset during the fourth bit of 5A.
    step(1'b1, 1'b1, 8'h5A, 1'b1, "rst");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00, 1'b1, "rst");
    check("rst_bit3", 32'({Q, valid}), 32'b11);
    step(1'b0, 1'b1, 8'hFF, 1'b1, "rst_apply");
    check("rst_out", 32'(dut_vec()), 32'b01000);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, 8'h00, 1'b1, "rst_quiet");
      if (done) ndone++;
    end
    check("rst_no_done", 32'(ndone), 32'd0);
    run_collect(8'h81, 1'b0, 8'h00, "post_rst", bits);
    check("post_rst_bits", 32'(bits), 32'h81);
    step(1'b1, 1'b0, 8'h00, 1'b1, "post_rst_idle");

    // load held high: back-to-back frames, done every WIDTH+2 cycles.
    d0 = -1; d1 = -1; d2t = -1;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b1, 8'h01, 1'b1, "b2b");
      if (done) begin
        if (d0 < 0) d0 = i; else if (d1 < 0) d1 = i; else if (d2t < 0) d2t = i;
      end
    end
    check("b2b_gap0", 32'(d1 - d0), 32'd10);
    check("b2b_gap1", 32'(d2t - d1), 32'd10);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 8'h00, 1'b1, "b2b_drain");

    // WIDTH=2 instance: Q=1 then 0, done in cycle k+3.
    load2 = 1'b1; d2 = 2'b10;
    step(1'b1, 1'b0, 8'h00, 1'b1, "w2_bg");
    load2 = 1'b0; d2 = 2'b00;
    check("w2_k1", 32'({q2, qd2, v2, b2, dn2}), 32'b10110);
    step(1'b1, 1'b0, 8'h00, 1'b1, "w2_bg");
    check("w2_k2", 32'({q2, qd2, v2, b2, dn2}), 32'b01110);
    step(1'b1, 1'b0, 8'h00, 1'b1, "w2_bg");
    check("w2_k3", 32'({q2, qd2, v2, b2, dn2}), 32'b01011);
    step(1'b1, 1'b0, 8'h00, 1'b1, "w2_bg");
    check("w2_k4", 32'({q2, qd2, v2, b2, dn2}), 32'b01000);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 31) != 0), ($urandom_range(0, 2) == 0), 8'($urandom),
           ($urandom_range(0, 3) != 0), "rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/latch_readout_serializer.md
LATCH_READOUT_SERIALIZER -- requirements
Module: latch_readout_serializer

Interface
REQ-001 Parameter: WIDTH, default 8, number of data bits captured and shifted out (legal range 2..32).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: D  input  WIDTH  parallel data, sampled only on load acceptance.
REQ-005 Port: load  input  1  capture request; level-sampled each rising edge.
REQ-006 Port: sout_ready  input  1  downstream ready; a bit transfers on a rising edge where valid=1 and sout_ready=1.
REQ-007 Port: Q  output  1  serial data bit, MSB first.
REQ-008 Port: Qdash  output  1  complement of Q.
REQ-009 Port: valid  output  1  Q holds a bit offered for transfer.
REQ-010 Port: busy  output  1  block not accepting load.
REQ-011 Port: done  output  1  one-cycle pulse after the last bit transfers.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-013 IDLE: valid=0, busy=0, done=0, Q=0; load=1 at an edge SHALL capture D into the shift register, set bit counter to WIDTH-1, and enter SHIFT.
REQ-014 SHIFT: valid=1, busy=1, done=0, Q=shift register MSB.
REQ-015 SHIFT with a transfer and counter>0: shift register shifts left by one (LSB filled 0), counter decrements, state stays SHIFT.
REQ-016 SHIFT with a transfer and counter=0: state goes to DONE.
REQ-017 SHIFT with sout_ready=0: shift register, counter, Q and valid SHALL hold unchanged (stall of any length).
REQ-018 DONE: valid=0, busy=1, done=1, Q=0, for exactly one cycle, then IDLE unconditionally.
REQ-019 load SHALL be ignored in SHIFT and DONE; D changes outside acceptance SHALL not affect Q.
REQ-020 Qdash SHALL equal the inverse of Q in every cycle, including reset.
REQ-021 Latency: with load accepted at edge k and sout_ready held 1, bit i (MSB=0) is on Q in cycle k+1+i, done asserts in cycle k+1+WIDTH, and load is accepted again at earliest at edge k+2+WIDTH.
REQ-022 Bit counter width SHALL be $clog2(WIDTH); counter SHALL never wrap below 0.
REQ-023 All outputs SHALL be registered or decoded from registered state only; no combinational path from sout_ready or load to any output.

Reset
REQ-024 rst_n=0 at a rising edge SHALL force IDLE, shift register=0, counter=0, giving Q=0, Qdash=1, valid=0, busy=0, done=0 on the next cycle.
REQ-025 Reset SHALL take priority over load and over an in-progress transfer; a shift aborted by reset produces no done pulse.
REQ-026 load sampled in the same edge as rst_n=0 SHALL be discarded.

Verification
REQ-027 WIDTH=8, D=8'hA5, load pulse, sout_ready=1 -> Q=1,0,1,0,0,1,0,1 in consecutive cycles, Qdash inverse, done pulse one cycle after last bit, then busy=0.
REQ-028 D=8'hC3, sout_ready dropped for 3 cycles after second bit -> Q holds 1 and valid holds 1 for the stall, sequence resumes 0,0,0,0,1,1, total 11 cycles load-to-done.
REQ-029 load=1 with D=8'hFF during SHIFT of 8'h0F and during DONE -> output remains 0,0,0,0,1,1,1,1; no second frame starts until IDLE.
REQ-030 rst_n=0 during fourth bit of 8'h5A -> next cycle Q=0, Qdash=1, valid=0, busy=0, no done pulse; subsequent load of 8'h81 yields 1,0,0,0,0,0,0,1.
REQ-031 load held continuously 1 with D=8'h01 -> frames back-to-back with exactly one DONE and one IDLE cycle between frames.
REQ-032 WIDTH=2, D=2'b10, sout_ready=1 -> Q=1 then 0, done in cycle k+3.
